// File: rtl/log2_req_arbiter.sv
// Purpose: share one pipelined log2 unit among NUM_REQ valid/ready requesters, routing results back by tag.
// Latency: handshake at cycle t gives rsp_vld at t+LAT+1; each stall cycle adds one.
// Backpressure: a held, unaccepted response drops u_en, freezing the unit and blocking new grants.

// In-order tag store: remembers which requester issued each in-flight operation.
module log2_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL_CNT) | do_pop);
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module log2_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 6,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            rsp_vld,
  input  logic [NUM_REQ-1:0]            rsp_rdy,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [DATA_WIDTH-1:0]         u_operand,
  output logic                          u_vld_in,
  output logic                          u_en,
  input  logic [DATA_WIDTH-1:0]         u_result,
  input  logic                          u_vld_out,
  output logic                          busy,
  output logic                          err_unexpected
);
  localparam int IW        = $clog2(NUM_REQ);
  localparam int CW        = $clog2(TAG_DEPTH + 1);
  localparam int MIN_DEPTH = LAT + 1;
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CREDIT_LIM = CW'(TAG_DEPTH);

  // The credit limit must cover every stage of the unit plus the hold register.
  if (TAG_DEPTH < MIN_DEPTH) begin : g_bad_depth
    $error("log2_req_arbiter: TAG_DEPTH must be at least LAT+1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("log2_req_arbiter: NUM_REQ must be in 2..8");
  end

  logic [IW-1:0]         rr_ptr;
  logic [CW-1:0]         inflight;
  logic                  hold_full;
  logic [IW-1:0]         hold_tag;
  logic [DATA_WIDTH-1:0] hold_data;

  logic                  grant_found;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         cand;
  logic                  can_issue;
  logic                  issue;
  logic                  rsp_fire;
  logic                  tag_empty;
  logic [IW-1:0]         pop_tag;
  logic                  result_seen;
  logic                  capture;
  logic                  unexpected;

  assign rsp_fire    = hold_full & rsp_rdy[hold_tag];
  assign u_en        = ~hold_full | rsp_fire;
  assign can_issue   = u_en & (inflight < CREDIT_LIM);
  // Grants are suppressed while reset is held so the unit never sees a stray vld_in.
  assign issue       = rst_n & can_issue & grant_found;
  assign u_vld_in    = issue;
  assign result_seen = u_en & u_vld_out;
  assign capture     = result_seen & ~tag_empty;
  assign unexpected  = result_seen & tag_empty;
  assign busy        = (inflight != '0) | hold_full;
  assign rsp_data    = hold_data;

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_vld[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Decode the issued grant into the one-hot ready and the operand mux.
  always_comb begin
    req_rdy   = '0;
    u_operand = '0;
    if (issue) begin
      req_rdy[grant_idx] = 1'b1;
      u_operand          = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The hold register presents its result only to the lane that issued it.
  always_comb begin
    rsp_vld           = '0;
    rsp_vld[hold_tag] = hold_full;
  end

  log2_tag_fifo #(
    .WIDTH (IW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue),
    .push_dat (grant_idx),
    .pop      (capture),
    .pop_dat  (pop_tag),
    .empty    (tag_empty)
  );

  // Pointer advances past the lane just served; it holds when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
    end
  end

  // In-flight credits are held from issue until the response is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (issue && !rsp_fire) begin
      inflight <= inflight + 1'b1;
    end else if (rsp_fire && !issue) begin
      inflight <= inflight - 1'b1;
    end
  end

  // Result capture wins over a same-cycle accept, allowing back-to-back responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_tag  <= '0;
      hold_data <= '0;
    end else if (capture) begin
      hold_full <= 1'b1;
      hold_tag  <= pop_tag;
      hold_data <= u_result;
    end else if (rsp_fire) begin
      hold_full <= 1'b0;
    end
  end

  // A result with no outstanding tag is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unexpected <= 1'b0;
    end else if (unexpected) begin
      err_unexpected <= 1'b1;
    end
  end
endmodule

// File: tb/tb_log2_req_arbiter.sv
module tb_log2_req_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DW        = 32;
  localparam int LAT       = 6;
  localparam int TAG_DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_vld;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    rsp_vld;
  logic [NUM_REQ-1:0]    rsp_rdy;
  logic [DW-1:0]         rsp_data;
  logic [DW-1:0]         u_operand;
  logic                  u_vld_in;
  logic                  u_en;
  logic [DW-1:0]         u_result;
  logic                  u_vld_out;
  logic                  busy;
  logic                  err_unexpected;
  logic                  inject;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int fire_count = 0;

  typedef struct {
    int          lane;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  log2_req_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .LAT(LAT), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_data(req_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data), .u_operand(u_operand), .u_vld_in(u_vld_in),
    .u_en(u_en), .u_result(u_result), .u_vld_out(u_vld_out),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  // Signed integer to IEEE single (exact for small magnitudes).
  function automatic logic [31:0] int_to_float(input int e);
    int          m;
    int          p;
    logic [31:0] mm;
    logic        s;
    if (e == 0) return 32'h0;
    s = (e < 0);
    m = s ? -e : e;
    p = 0;
    for (int i = 0; i < 8; i++) if ((m >> i) != 0) p = i;
    mm = 32'(m) << (23 - p);
    return {s, 8'(127 + p), mm[22:0]};
  endfunction

  // log2 of zero or a positive power of two: -inf, or the unbiased exponent as a float.
  function automatic logic [31:0] log2_ref(input logic [31:0] x);
    if (x[30:0] == 31'h0) return 32'hFF800000;
    return int_to_float(int'(x[30:23]) - 127);
  endfunction

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 9) == 0) return 32'h0;
    return {1'b0, 8'($urandom_range(1, 254)), 23'h0};
  endfunction

  function automatic int idx_of(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Behavioural pipelined log2 unit with global enable; shares the reset.
  logic [LAT-1:0] pv;
  logic [31:0]    pd [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else if (u_en) begin
      pv    <= {pv[LAT-2:0], u_vld_in};
      pd[0] <= log2_ref(u_operand);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign u_vld_out = pv[LAT-1] | inject;
  assign u_result  = pd[LAT-1];

  // Reference model + scoreboard monitor, sampled mid-cycle.
  int               m_inflight;
  int               m_last;
  int               m_lane;
  int               mj;
  logic             m_hold;
  logic             m_uen;
  logic [NUM_REQ-1:0] m_rdy;
  logic [NUM_REQ-1:0] m_fire;
  logic [31:0]      m_op;
  exp_t             m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      m_inflight = 0;
      m_last     = NUM_REQ - 1;
    end else begin
      m_hold = |rsp_vld;
      m_fire = rsp_vld & rsp_rdy;
      m_uen  = !m_hold || (|m_fire);
      chk("u_en", 32'(u_en), 32'(m_uen));
      chk("busy", 32'(busy), 32'(m_inflight != 0));
      m_lane = -1;
      if (m_uen && m_inflight < TAG_DEPTH) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          mj = (m_last + k) % NUM_REQ;
          if (req_vld[mj] && m_lane < 0) m_lane = mj;
        end
      end
      m_rdy = '0;
      m_op  = '0;
      if (m_lane >= 0) begin
        m_rdy[m_lane] = 1'b1;
        m_op = req_data[m_lane*DW +: DW];
      end
      chk("req_rdy", 32'(req_rdy), 32'(m_rdy));
      chk("u_vld_in", 32'(u_vld_in), 32'(m_lane >= 0));
      chk("u_operand", u_operand, m_op);
      if (m_hold) begin
        chk("rsp_onehot", 32'($countones(rsp_vld)), 32'd1);
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_vld), 32'h0);
        end else begin
          chk("rsp_lane", 32'(idx_of(rsp_vld)), 32'(sbq[0].lane));
          chk("rsp_data", rsp_data, sbq[0].data);
        end
      end
      if (|m_fire) begin
        if (sbq.size() != 0) void'(sbq.pop_front());
        m_inflight--;
        fire_count++;
      end
      if (|(req_vld & req_rdy)) hs_count++;
      if (m_lane >= 0) begin
        m_e.lane = m_lane;
        m_e.data = log2_ref(req_data[m_lane*DW +: DW]);
        sbq.push_back(m_e);
        m_inflight++;
        m_last = m_lane;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = rand_op();
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) done = 1'b1;
      else step();
    end
    chk("drain_done", 32'(done), 32'd1);
    step();
  endtask

  // One isolated operation: checks grant, exact latency, and result value.
  task automatic send_one(input int lane, input logic [31:0] d, input logic [31:0] exp_d);
    int   n;
    logic found;
    req_data[lane*DW +: DW] = d;
    req_vld = '0;
    req_vld[lane] = 1'b1;
    @(negedge clk);
    chk("one_grant", 32'(req_rdy), 32'(1) << lane);
    step();
    req_vld = '0;
    n = 1;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rsp_vld[lane]) begin
        found = 1'b1;
        break;
      end
      step();
      n++;
    end
    chk("one_found", 32'(found), 32'd1);
    chk("one_latency", 32'(n), 32'(LAT + 1));
    chk("one_data", rsp_data, exp_d);
    step();
  endtask

  initial begin
    int          ng;
    int          nr;
    int          rl [8];
    int          rc [8];
    int          h0;
    int          f0;
    logic        found;
    logic [31:0] held;

    rst_n    = 1'b0;
    req_vld  = '0;
    rsp_rdy  = '1;
    req_data = '0;
    inject   = 1'b0;
    #3;
    chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_err", 32'(err_unexpected), 32'h0);
    chk("rst_u_en", 32'(u_en), 32'h1);
    chk("rst_u_vld_in", 32'(u_vld_in), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Round-robin: all lanes requesting, then responses in the same order.
    req_vld = '1;
    rand_data();
    ng = 0;
    nr = 0;
    for (int c = 0; c < 40 && nr < 8; c++) begin
      @(negedge clk);
      if (ng < 8) begin
        chk("rr_grant", 32'(req_rdy), 32'(1) << (ng % NUM_REQ));
        ng++;
      end
      if (|(rsp_vld & rsp_rdy)) begin
        rl[nr] = idx_of(rsp_vld);
        rc[nr] = c;
        nr++;
      end
      step();
      if (ng == 8) req_vld = '0;
      rand_data();
    end
    chk("rr_rsp_count", 32'(nr), 32'd8);
    for (int i = 0; i < 8; i++) if (i < nr) chk("rr_rsp_order", 32'(rl[i]), 32'(i % NUM_REQ));
    if (nr == 8) chk("rr_rsp_back_to_back", 32'(rc[7] - rc[0]), 32'd7);
    drain();

    // Single operation latency and busy fall.
    send_one(2, 32'h41000000, 32'h40400000);
    @(negedge clk);
    chk("single_busy_low", 32'(busy), 32'h0);
    step();

    // Backpressure on lane 1 while lanes 0 and 3 keep requesting.
    rsp_rdy = 4'b1101;
    rand_data();
    req_vld = 4'b0010;
    @(negedge clk);
    chk("bp_grant1", 32'(req_rdy), 32'h2);
    step();
    req_vld = 4'b0001;
    @(negedge clk);
    chk("bp_grant0", 32'(req_rdy), 32'h1);
    step();
    req_vld = 4'b1001;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_vld[1]) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("bp_held", 32'(found), 32'd1);
    held = rsp_data;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      chk("bp_u_en", 32'(u_en), 32'h0);
      chk("bp_stable", rsp_data, held);
      chk("bp_no_grant", 32'(req_rdy), 32'h0);
      step();
      rand_data();
    end
    rsp_rdy = '1;
    for (int c = 0; c < 5; c++) step();
    req_vld = '0;
    drain();

    // Credit limit with every response blocked.
    rsp_rdy = '0;
    req_vld = 4'b0001;
    h0 = hs_count;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      step();
      rand_data();
    end
    chk("credit_issued", 32'(hs_count - h0), 32'd7);
    req_vld = '0;
    f0 = fire_count;
    rsp_rdy = '1;
    drain();
    chk("credit_returned", 32'(fire_count - f0), 32'd7);

    // Special values.
    send_one(3, 32'h00000000, 32'hFF800000);
    send_one(0, 32'h3F800000, 32'h00000000);
    drain();

    // Randomized traffic with random response backpressure.
    for (int c = 0; c < 400; c++) begin
      req_vld = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      rand_data();
      for (int i = 0; i < NUM_REQ; i++) rsp_rdy[i] = ($urandom_range(0, 3) != 0);
      step();
    end
    req_vld = '0;
    rsp_rdy = '1;
    drain();

    // Spurious unit result with no outstanding tag.
    inject = 1'b1;
    step();
    inject = 1'b0;
    @(negedge clk);
    chk("unexp_err", 32'(err_unexpected), 32'h1);
    chk("unexp_no_rsp", 32'(rsp_vld), 32'h0);
    chk("unexp_busy", 32'(busy), 32'h0);
    step();

    // Asynchronous reset in the middle of traffic.
    req_vld = '1;
    for (int c = 0; c < 10; c++) begin
      rand_data();
      step();
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("arst_rsp_data", rsp_data, 32'h0);
    chk("arst_err", 32'(err_unexpected), 32'h0);
    chk("arst_u_en", 32'(u_en), 32'h1);
    chk("arst_u_vld_in", 32'(u_vld_in), 32'h0);
    chk("arst_req_rdy", 32'(req_rdy), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    step();
    step();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_first_grant", 32'(req_rdy), 32'h1);
    for (int c = 0; c < 6; c++) step();
    req_vld = '0;
    drain();
    chk("arst_err_after", 32'(err_unexpected), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
